// File: rtl/frame_pkg.sv
// Shared frame geometry and writer state types.
// Used by the frame writer and the Sobel reader.
package frame_pkg;

  localparam int IMG_WIDTH  = 1280;
  localparam int IMG_HEIGHT = 720;
  localparam int PIXEL_BITS = 24;
  localparam int ADDR_WIDTH = 20;

  typedef logic [PIXEL_BITS-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } wr_state_t;

endpackage

// File: rtl/frame_buffer_writer_addr_counter.sv
// Raster x/y position and linear address tracking.
// The address is advanced incrementally; line jumps reload it from line_base.
module raster_addr_counter #(
  parameter int W  = 1280,
  parameter int H  = 720,
  parameter int AW = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc_i,
  input  logic          eol_jump_i,
  input  logic          clear_i,
  output logic [AW-1:0] addr_o,
  output logic          last_col_o,
  output logic          last_pix_o
);

  localparam int XW = (W > 1) ? $clog2(W) : 1;
  localparam int YW = (H > 1) ? $clog2(H) : 1;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] base_q, base_d;
  logic          last_row;

  assign last_row   = (y_q == YW'(H - 1));
  assign last_col_o = (x_q == XW'(W - 1));
  assign last_pix_o = last_col_o && last_row;
  assign addr_o     = addr_q;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    base_d = base_q;
    if (clear_i) begin
      // clear together with inc means the sof beat at 0 was just taken
      x_d    = inc_i ? XW'(1) : '0;
      y_d    = '0;
      addr_d = inc_i ? AW'(1) : '0;
      base_d = '0;
    end else if (inc_i) begin
      if (eol_jump_i) begin
        x_d = '0;
        if (last_row) begin
          y_d    = '0;
          addr_d = '0;
          base_d = '0;
        end else begin
          y_d    = y_q + YW'(1);
          addr_d = base_q + AW'(W);
          base_d = base_q + AW'(W);
        end
      end else begin
        x_d    = x_q + XW'(1);
        addr_d = addr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
      base_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
      base_q <= base_d;
    end
  end

endmodule

// File: rtl/frame_buffer_writer.sv
// Write side of the shared frame BRAM: raster stream in, linear writes out.
// Publishes frame_valid once a full frame has landed.
import frame_pkg::*;

module frame_buffer_writer #(
  parameter int IMG_WIDTH  = frame_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = frame_pkg::IMG_HEIGHT,
  parameter int PIXEL_BITS = frame_pkg::PIXEL_BITS,
  parameter int ADDR_WIDTH = frame_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PIXEL_BITS-1:0] s_data,
  input  logic                  s_sof,
  input  logic                  s_eol,
  input  logic                  consumer_busy,
  output logic                  bram_wr_en,
  output logic [ADDR_WIDTH-1:0] bram_wr_addr,
  output logic [PIXEL_BITS-1:0] bram_wr_data,
  output logic                  frame_valid,
  output logic                  frame_done,
  output logic                  line_err
);

  wr_state_t             state_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [PIXEL_BITS-1:0] wr_data_q;
  logic                  frame_valid_q;
  logic                  frame_done_q;
  logic                  line_err_q;

  logic                  acc;
  logic                  cnt_inc;
  logic                  cnt_jump;
  logic                  cnt_clear;
  logic [ADDR_WIDTH-1:0] cnt_addr;
  logic                  last_col;
  logic                  last_pix;

  assign s_ready = !reset &&
    ((state_q == IDLE && !consumer_busy) || state_q == WRITE);
  assign acc = s_valid && s_ready;

  raster_addr_counter #(
    .W  (IMG_WIDTH),
    .H  (IMG_HEIGHT),
    .AW (ADDR_WIDTH)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (cnt_inc),
    .eol_jump_i (cnt_jump),
    .clear_i    (cnt_clear),
    .addr_o     (cnt_addr),
    .last_col_o (last_col),
    .last_pix_o (last_pix)
  );

  always_comb begin
    cnt_inc   = 1'b0;
    cnt_jump  = 1'b0;
    cnt_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc && s_sof) begin
          cnt_clear = 1'b1;
          cnt_inc   = 1'b1;
        end
      end
      WRITE: begin
        if (acc) begin
          if (s_sof) begin
            cnt_clear = 1'b1;
            cnt_inc   = 1'b1;
          end else if (last_pix) begin
            cnt_clear = 1'b1;
          end else begin
            cnt_inc  = 1'b1;
            cnt_jump = s_eol || last_col;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (acc && s_sof) begin
            wr_en_q       <= 1'b1;
            wr_addr_q     <= '0;
            wr_data_q     <= s_data;
            frame_valid_q <= 1'b0;
            state_q       <= WRITE;
          end
        end
        WRITE: begin
          if (acc) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= s_data;
            if (s_sof) begin
              wr_addr_q  <= '0;
              line_err_q <= 1'b1;
            end else begin
              wr_addr_q  <= cnt_addr;
              // short or long line; the final pixel is accepted either way
              line_err_q <= (s_eol != last_col) && !last_pix;
              if (last_pix) state_q <= DONE;
            end
          end
        end
        DONE: begin
          frame_done_q  <= 1'b1;
          frame_valid_q <= 1'b1;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bram_wr_en   = wr_en_q;
  assign bram_wr_addr = wr_addr_q;
  assign bram_wr_data = wr_data_q;
  assign frame_valid  = frame_valid_q;
  assign frame_done   = frame_done_q;
  assign line_err     = line_err_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Scoreboard bench for frame_buffer_writer on a 4x3 frame.
module tb_frame_buffer_writer;

  logic        clk;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        s_sof;
  logic        s_eol;
  logic        consumer_busy;
  logic        bram_wr_en;
  logic [3:0]  bram_wr_addr;
  logic [23:0] bram_wr_data;
  logic        frame_valid;
  logic        frame_done;
  logic        line_err;

  typedef struct {
    logic [3:0]  addr;
    logic [23:0] data;
    logic        err;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;
  logic done_pend = 1'b0;

  frame_buffer_writer #(
    .IMG_WIDTH  (4),
    .IMG_HEIGHT (3),
    .PIXEL_BITS (24),
    .ADDR_WIDTH (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_sof         (s_sof),
    .s_eol         (s_eol),
    .consumer_busy (consumer_busy),
    .bram_wr_en    (bram_wr_en),
    .bram_wr_addr  (bram_wr_addr),
    .bram_wr_data  (bram_wr_data),
    .frame_valid   (frame_valid),
    .frame_done    (frame_done),
    .line_err      (line_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      passed++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("frame_done", frame_done, done_pend);
    done_pend = 1'b0;
    if (bram_wr_en) begin
      if (q.size() == 0) begin
        chk("unexp_wr", bram_wr_en, 0);
      end else begin
        e = q.pop_front();
        chk("wr_addr", bram_wr_addr, e.addr);
        chk("wr_data", bram_wr_data, e.data);
        chk("line_err", line_err, e.err);
        done_pend = e.last;
      end
    end else begin
      chk("line_err_idle", line_err, 0);
    end
  end

  task automatic beat(input logic sof, input logic eol, input logic wr,
                      input logic [3:0] a, input logic err);
    exp_t e;
    int   n;
    s_data  = 24'($urandom);
    s_sof   = sof;
    s_eol   = eol;
    s_valid = 1'b1;
    #1;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!s_ready) begin
      chk("accept_timeout", s_ready, 1);
    end else if (wr) begin
      e.addr = a;
      e.data = s_data;
      e.err  = err;
      e.last = (a == 4'd11) && !sof;
      q.push_back(e);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
  endtask

  task automatic run_to_end(input int start);
    for (int a = start; a < 12; a++)
      beat(1'b0, (a % 4) == 3, 1'b1, 4'(a), 1'b0);
  endtask

  task automatic clean_frame();
    beat(1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
    run_to_end(1);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_wr_en"}, bram_wr_en, 0);
    chk({tag, "_addr"}, bram_wr_addr, 0);
    chk({tag, "_data"}, bram_wr_data, 0);
    chk({tag, "_fvalid"}, frame_valid, 0);
    chk({tag, "_fdone"}, frame_done, 0);
    chk({tag, "_lerr"}, line_err, 0);
  endtask

  initial begin
    reset = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_sof = 1'b0;
    s_eol = 1'b0;
    consumer_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outs("rst");
    chk("rst_ready", s_ready, 0);
    reset = 1'b0;
    @(negedge clk);

    // garbage before sof, then a clean frame
    for (int i = 0; i < 3; i++) beat(1'b0, i == 2, 1'b0, 4'd0, 1'b0);
    clean_frame();
    repeat (2) @(negedge clk);
    chk("fvalid_clean", frame_valid, 1);

    // short line 0: eol on its 2nd pixel
    beat(1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
    beat(1'b0, 1'b1, 1'b1, 4'd1, 1'b1);
    run_to_end(4);
    repeat (2) @(negedge clk);
    chk("fvalid_short", frame_valid, 1);

    // sof again where addr 6 was due
    beat(1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
    for (int a = 1; a < 6; a++)
      beat(1'b0, (a % 4) == 3, 1'b1, 4'(a), 1'b0);
    beat(1'b1, 1'b0, 1'b1, 4'd0, 1'b1);
    run_to_end(1);
    repeat (2) @(negedge clk);
    chk("fvalid_midsof", frame_valid, 1);

    // consumer busy holds off the next frame
    consumer_busy = 1'b1;
    s_sof = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_ready", s_ready, 0);
    end
    chk("busy_fvalid", frame_valid, 1);
    s_valid = 1'b0;
    s_sof = 1'b0;
    consumer_busy = 1'b0;
    beat(1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
    chk("fvalid_drop", frame_valid, 0);
    run_to_end(1);
    repeat (2) @(negedge clk);

    // reset partway through a frame
    beat(1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
    for (int a = 1; a < 5; a++)
      beat(1'b0, (a % 4) == 3, 1'b1, 4'(a), 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk_zero_outs("midrst");
    reset = 1'b0;
    @(negedge clk);
    clean_frame();
    repeat (3) @(negedge clk);
    chk("fvalid_after_rst", frame_valid, 1);
    chk("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
